csa_multiword_sequencer: RTL and testbench
==========================================

Name: csa_multiword_sequencer

Overview:
Multi-precision add controller. It sequences one instance of the team's 8-bit conditional_sum_adder over WORDS byte lanes, least-significant byte first, one byte per clock. The inter-byte carry is held in a register between cycles. It sits between a register-file/ALU front end, which issues wide add requests, and the shared 8-bit adder datapath.

Parameters:
WORDS, 4, number of byte lanes per operand (legal range 1..255); operand width = 8*WORDS.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only in IDLE.
op_a  input  8*WORDS  operand A; captured on accepted start.
op_b  input  8*WORDS  operand B; captured on accepted start.
cin  input  1  carry-in to byte 0; captured on accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when result and cout are valid.
result  output  8*WORDS  sum; held stable from done until the next accepted start.
cout  output  1  carry out of the most-significant byte; held like result.

Behaviour:
- Reset (rst_n=0, takes effect immediately, also mid-operation):
  - state=IDLE.
  - busy, done, cout = 0; result = 0.
  - internal operand shift registers, carry register and byte counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge: capture op_a/op_b into shift registers, carry_reg <= cin, cnt <= 0, go to RUN.
  - result and cout keep their previous values until the first RUN cycle overwrites them.
- RUN, each cycle:
  - Adder inputs are x = a_sh[7:0], y = b_sh[7:0], cin = carry_reg.
  - On the edge: sum byte shifts into result from the MSB end (result <= {sum, result[8*WORDS-1:8]}); a_sh and b_sh shift right by 8; carry_reg <= adder cout; cnt <= cnt+1.
  - When cnt == WORDS-1, the same edge also sets cout <= adder cout and moves to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start sampled at edge 0.
  - RUN occupies cycles 1..WORDS.
  - done is high in cycle WORDS+1.
  - Next start is accepted no earlier than edge WORDS+2, so throughput is one op per WORDS+2 cycles.
- start while busy=1 (RUN or DONE) is ignored and not queued. op_a/op_b/cin changes after capture have no effect.
- WORDS=1: a single RUN cycle, then DONE. cnt is 8 bits wide, with no wrap within the legal range.
- Arithmetic:
  - Unsigned modulo 2^(8*WORDS).
  - {cout, result} == op_a + op_b + cin for all inputs.
  - No overflow flag.
- The adder instance is purely combinational. All registers are in this block; no combinational path from start to outputs.

Optional Feature:
Macro SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - When sub=1: op_b is bitwise inverted on capture and carry_reg <= 1 (cin ignored).
  - result = op_a - op_b mod 2^(8*WORDS); cout = 1 means no borrow (op_a >= op_b).
  - sub=0 behaves exactly as the baseline.
- Undefined: no sub port; add only.

Test Plan:
- Reset, then idle 3 cycles -> busy=0, done=0, result=0, cout=0.
- WORDS=4, op_a=0x000000FF, op_b=0x00000001, cin=0, start at edge 0 -> busy high from cycle 1; done pulses only in cycle 5; result=0x00000100, cout=0; held until next start.
- op_a=0xFFFFFFFF, op_b=0x00000000, cin=1 -> carry ripples through all 4 bytes; result=0x00000000, cout=1. Then op_a=0x80000000, op_b=0x80000000, cin=0 -> result=0x00000000, cout=1.
- Start op (0x12345678 + 0x11111111, cin=0); at edge 2 pulse start with op_a=op_b=0xFFFFFFFF -> second start ignored; result=0x23456789, cout=0; exactly one done pulse.
- Assert rst_n=0 during cycle 2 of an op -> outputs clear immediately, no done. After release, start 0x00000001+0x00000001 -> result=0x00000002 at cycle 5.
- SUB_EN: op_a=0x00000010, op_b=0x00000020, sub=1 -> result=0xFFFFFFF0, cout=0. op_a=0x20, op_b=0x10, sub=1 -> result=0x00000010, cout=1.

Source files
------------

// File: rtl/csa_multiword_sequencer.sv
// Multi-precision adder: sequences an 8-bit conditional-sum adder over WORDS bytes, LSB first.
// Optional macro SUB_EN adds a sub port for two's-complement subtraction.
module conditional_sum_adder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // Both upper-nibble sums are formed in parallel; the low carry picks one.
  assign lo  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, ci};
  assign hi0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
  assign hi1 = {1'b0, x[7:4]} + {1'b0, y[7:4]} + 5'd1;

  always_comb begin
    s  = {hi0[3:0], lo[3:0]};
    co = hi0[4];
    if (lo[4]) begin
      s  = {hi1[3:0], lo[3:0]};
      co = hi1[4];
    end
  end
endmodule

module csa_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8*WORDS-1:0]   op_a,
  input  logic [8*WORDS-1:0]   op_b,
  input  logic                 cin,
`ifdef SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout
);
  localparam int W = 8 * WORDS;
  localparam logic [7:0] LAST = 8'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0] a_sh;
  logic [W-1:0] b_sh;
  logic [W-1:0] a_nxt;
  logic [W-1:0] b_nxt;
  logic [W-1:0] res_nxt;
  logic         carry_reg;
  logic [7:0]   cnt;
  logic [7:0]   sum;
  logic         sum_co;
  logic [W-1:0] b_cap;
  logic         c_cap;
  logic         last;

  conditional_sum_adder u_add (
    .x  (a_sh[7:0]),
    .y  (b_sh[7:0]),
    .ci (carry_reg),
    .s  (sum),
    .co (sum_co)
  );

  generate
    if (WORDS == 1) begin : g_one
      assign a_nxt   = '0;
      assign b_nxt   = '0;
      assign res_nxt = sum;
    end else begin : g_multi
      assign a_nxt   = {8'h00, a_sh[W-1:8]};
      assign b_nxt   = {8'h00, b_sh[W-1:8]};
      assign res_nxt = {sum, result[W-1:8]};
    end
  endgenerate

`ifdef SUB_EN
  assign b_cap = sub ? ~op_b : op_b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = op_b;
  assign c_cap = cin;
`endif

  assign last = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      cout      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh      <= op_a;
            b_sh      <= b_cap;
            carry_reg <= c_cap;
            cnt       <= '0;
          end
        end
        RUN: begin
          result    <= res_nxt;
          a_sh      <= a_nxt;
          b_sh      <= b_nxt;
          carry_reg <= sum_co;
          cnt       <= cnt + 8'd1;
          if (last) cout <= sum_co;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_multiword_sequencer.sv
// Directed bench for csa_multiword_sequencer (WORDS=4).
// Vector table of wide adds plus hand sequences for ignore/reset corners.
module tb_csa_multiword_sequencer;
  localparam int WORDS = 4;
  localparam int W = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
`ifdef SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csa_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
`ifdef SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] r;
    logic         co;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start before edge 0, return at cycle where done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output int n);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    cin   = ~c;
    chk("busy_c1", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int dn;
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vecs[4] = '{32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0};

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_result", 64'(result), 64'd0);
    chk("idle_cout", 64'(cout), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, n);
      chk($sformatf("lat_%0d", i), 64'(n), 64'd5);
      chk($sformatf("res_%0d", i), 64'(result), 64'(vecs[i].r));
      chk($sformatf("cout_%0d", i), 64'(cout), 64'(vecs[i].co));
      tick();
      chk($sformatf("done_off_%0d", i), 64'(done), 64'd0);
      chk($sformatf("busy_off_%0d", i), 64'(busy), 64'd0);
      tick();
      chk($sformatf("hold_%0d", i), 64'(result), 64'(vecs[i].r));
    end

    // Start while busy must be ignored.
    op_a = 32'h12345678;
    op_b = 32'h11111111;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op_a = 32'hFFFFFFFF;
    op_b = 32'hFFFFFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) dn++;
      tick();
    end
    chk("ign_dones", 64'(dn), 64'd1);
    chk("ign_result", 64'(result), 64'h23456789);
    chk("ign_cout", 64'(cout), 64'd0);
    chk("ign_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of an op.
    op_a = 32'hFFFFFFFF;
    op_b = 32'h00000001;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_result", 64'(result), 64'd0);
    chk("mrst_cout", 64'(cout), 64'd0);
    tick();
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dn++;
      tick();
    end
    chk("mrst_nodone", 64'(dn), 64'd0);
    run_op(32'h00000001, 32'h00000001, 1'b0, n);
    chk("post_lat", 64'(n), 64'd5);
    chk("post_res", 64'(result), 64'h00000002);
    chk("post_cout", 64'(cout), 64'd0);
    tick();

`ifdef SUB_EN
    sub = 1'b1;
    run_op(32'h00000010, 32'h00000020, 1'b0, n);
    chk("sub1_res", 64'(result), 64'hFFFFFFF0);
    chk("sub1_cout", 64'(cout), 64'd0);
    tick();
    sub = 1'b1;
    run_op(32'h00000020, 32'h00000010, 1'b0, n);
    chk("sub2_res", 64'(result), 64'h00000010);
    chk("sub2_cout", 64'(cout), 64'd1);
    tick();
    sub = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
